fir_mac_engine: RTL and testbench

Time-multiplexed multiply-accumulate core of the FIR filter. Accepts one input sample per handshake, stores it in an internal circular delay line, then spends NUMBER_OF_TAPS cycles driving `current_count` into the `coeffs` selector and accumulating sample × coefficient. It presents one full-precision output per input sample over a valid/ready handshake. It sits directly downstream of `coeffs` and consumes its `coeff` output.

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_delay_line.sv | 32 +++
 rtl/fir_mac_engine.sv | 125 ++++++++++++
 tb/tb_fir_mac_engine.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and width rules for the FIR multiply-accumulate engine.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  // Accumulator wide enough that summing every tap can never overflow.
  function automatic int acc_width(input int data_bits, input int coeff_bits, input int taps);
    return data_bits + coeff_bits + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample store: one synchronous write port, one combinational read port,
// cleared to zero on reset.
module fir_delay_line #(
  parameter int TAPS      = 64,
  parameter int DATA_BITS = 16,
  parameter int IDX_BITS  = $clog2(TAPS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [IDX_BITS-1:0]         wp,
  input  logic signed [DATA_BITS-1:0] wr_data,
  input  logic [IDX_BITS-1:0]         idx,
  output logic signed [DATA_BITS-1:0] rd_data
);

  logic signed [DATA_BITS-1:0] mem_r [TAPS];

  // Sample storage with full clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      mem_r[wp] <= wr_data;
    end
  end

  assign rd_data = mem_r[idx];

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR MAC: one sample in, NUMBER_OF_TAPS accumulate cycles,
// one full-precision result out over valid/ready.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int NUMBER_OF_TAPS = 64,
  parameter int COEFF_BITS     = 16,
  parameter int DATA_BITS      = 16,
  localparam int COUNTER_BITS  = $clog2(NUMBER_OF_TAPS),
  localparam int ACC_BITS      = acc_width(DATA_BITS, COEFF_BITS, NUMBER_OF_TAPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_BITS-1:0]  in_sample,
  output logic [COUNTER_BITS-1:0]      current_count,
  input  logic signed [COEFF_BITS-1:0] coeff,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_BITS-1:0]   out_data,
  output logic                         busy
);

  localparam int PROD_BITS = DATA_BITS + COEFF_BITS;
  localparam logic [COUNTER_BITS-1:0] LAST_IDX  = COUNTER_BITS'(NUMBER_OF_TAPS - 1);
  localparam logic [COUNTER_BITS-1:0] TAPS_MOD  = COUNTER_BITS'(NUMBER_OF_TAPS);

  fir_state_t                  state_r;
  logic [COUNTER_BITS-1:0]     wp_r;
  logic [ACC_BITS-1:0]         acc_r;
  logic [COUNTER_BITS-1:0]     idx_s;
  logic signed [DATA_BITS-1:0] rd_sample_s;
  logic signed [PROD_BITS-1:0] prod_s;
  logic [ACC_BITS-1:0]         acc_next_s;
  logic                        wr_en_s;

  assign wr_en_s = (state_r == IDLE) && in_ready && in_valid;

  fir_delay_line #(
    .TAPS      (NUMBER_OF_TAPS),
    .DATA_BITS (DATA_BITS),
    .IDX_BITS  (COUNTER_BITS)
  ) u_delay_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_s),
    .wp      (wp_r),
    .wr_data (in_sample),
    .idx     (idx_s),
    .rd_data (rd_sample_s)
  );

  // Tap read index x[n-count]; the wrap branch is exact modulo 2^COUNTER_BITS
  // because the true result is always below NUMBER_OF_TAPS.
  always_comb begin
    idx_s = wp_r - current_count;
    if (wp_r >= current_count) begin
      idx_s = wp_r - current_count;
    end else begin
      idx_s = wp_r + TAPS_MOD - current_count;
    end
  end

  assign prod_s = $signed({{COEFF_BITS{rd_sample_s[DATA_BITS-1]}}, rd_sample_s}) *
                  $signed({{DATA_BITS{coeff[COEFF_BITS-1]}}, coeff});
  assign acc_next_s = acc_r + {{(ACC_BITS-PROD_BITS){prod_s[PROD_BITS-1]}}, prod_s};

  // Control FSM, tap counter, write pointer and accumulator with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      wp_r          <= '0;
      acc_r         <= '0;
      current_count <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      busy          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_ready && in_valid) begin
            in_ready      <= 1'b0;
            busy          <= 1'b1;
            current_count <= '0;
            acc_r         <= '0;
            state_r       <= MAC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        MAC: begin
          acc_r <= acc_next_s;
          if (current_count == LAST_IDX) begin
            out_data      <= acc_next_s;
            out_valid     <= 1'b1;
            current_count <= '0;
            state_r       <= DONE;
          end else begin
            current_count <= current_count + 1'b1;
          end
        end
        DONE: begin
          // wp moves only on acceptance so a stalled result never sees a new sample.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            wp_r      <= (wp_r == LAST_IDX) ? '0 : wp_r + 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r       <= IDLE;
          current_count <= '0;
          in_ready      <= 1'b0;
          out_valid     <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: 64-tap instance plus a 5-tap instance,
// compared against a convolution model over the accepted-sample history.
module tb_fir_mac_engine;

  localparam int N  = 64;
  localparam int NB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [15:0] in_sample, coeff;
  logic [5:0]         current_count;
  logic signed [37:0] out_data;

  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic signed [15:0] b_in_sample, b_coeff;
  logic [2:0]         b_count;
  logic signed [34:0] b_out_data;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  int     ca [64];
  int     cb [64];
  longint ha [$];
  longint hb [$];

  assign coeff   = 16'(ca[current_count]);
  assign b_coeff = (b_count < 3'd5) ? 16'(cb[b_count]) : 16'sd0;

  always @(posedge clk) cyc <= cyc + 1;

  fir_mac_engine #(.NUMBER_OF_TAPS(N), .COEFF_BITS(16), .DATA_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .current_count(current_count), .coeff(coeff),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  fir_mac_engine #(.NUMBER_OF_TAPS(NB), .COEFF_BITS(16), .DATA_BITS(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sample(b_in_sample), .current_count(b_count), .coeff(b_coeff),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  // y[n] = sum over taps of c[i] * x[n-i], missing history treated as zero.
  function automatic longint fir_ref(input int taps, input int c[64], input longint h[$]);
    longint y = 0;
    for (int i = 0; i < taps; i++) begin
      if (i < h.size()) y += longint'(c[i]) * h[h.size()-1-i];
    end
    return y;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", current_count, 0);
    chk("rst_b_busy", b_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready_after", in_ready, 1);
    ha.delete();
    hb.delete();
  endtask

  task automatic run_a(input int s, input int hold, input bit hold_in, input int nxt);
    int     w;
    int     acc_cyc;
    longint y;
    in_sample = 16'(s);
    in_valid  = 1'b1;
    w = 0;
    while (!in_ready && w < 300) begin @(negedge clk); w++; end
    chk("a_accept_wait", (w < 300), 1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    ha.push_back(longint'(16'(s)));
    y = fir_ref(N, ca, ha);
    chk("a_in_ready_mac", in_ready, 0);
    chk("a_busy_mac", busy, 1);
    w = 0;
    while (!out_valid && w < 300) begin @(negedge clk); w++; end
    chk("a_latency", cyc - acc_cyc, N + 1);
    chk("a_out_data", out_data, y);
    for (int k = 0; k < hold; k++) begin
      if (hold_in) begin in_valid = 1'b1; in_sample = 16'(nxt); end
      @(negedge clk);
      chk("a_hold_data", out_data, y);
      chk("a_hold_valid", out_valid, 1);
      chk("a_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("a_release", out_valid, 0);
  endtask

  task automatic run_b(input int s);
    int w;
    int acc_cyc;
    b_in_sample = 16'(s);
    b_in_valid  = 1'b1;
    w = 0;
    while (!b_in_ready && w < 50) begin @(negedge clk); w++; end
    chk("b_accept_wait", (w < 50), 1);
    acc_cyc = cyc;
    @(negedge clk);
    b_in_valid = 1'b0;
    hb.push_back(longint'(16'(s)));
    w = 0;
    while (!b_out_valid && w < 50) begin @(negedge clk); w++; end
    chk("b_latency", cyc - acc_cyc, NB + 1);
    chk("b_out_data", b_out_data, fir_ref(NB, cb, hb));
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int s;
    int nxt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sample = 16'sd0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_sample = 16'sd0;
    for (int i = 0; i < 64; i++) begin ca[i] = i + 1; cb[i] = (i < NB) ? i + 1 : 0; end
    @(negedge clk);
    reset_dut();

    // impulse on both instances; the 5-tap one continues with random data to wrap idx
    for (int k = 0; k < N; k++) run_a((k == 0) ? 1 : 0, 0, 1'b0, 0);
    for (int k = 0; k < 12; k++) run_b((k == 0) ? 1 : ((k < 6) ? 0 : rnd16()));

    // step of 3 through the wrap of wp, with a 20-cycle stall and a held producer
    for (int i = 0; i < 64; i++) ca[i] = 1;
    for (int k = 0; k < 100; k++) run_a(3, (k == 50) ? 20 : 0, (k == 50), 3);
    chk("step_final", out_data, 192);

    // extreme negative values
    for (int i = 0; i < 64; i++) ca[i] = -32768;
    for (int k = 0; k < N; k++) run_a(-32768, 0, 1'b0, 0);
    chk("extreme_final", out_data, 64'sd68719476736);

    // reset in the middle of an accumulation
    for (int i = 0; i < 64; i++) ca[i] = rnd16();
    in_sample = 16'sd1234;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (current_count != 6'd30 && w < 200) begin @(negedge clk); w++; end
    chk("mid_mac_reach30", current_count, 30);
    reset_dut();
    run_a(1, 0, 1'b0, 0);
    chk("post_reset_impulse", out_data, ca[0]);

    // random coefficients, samples, stalls and held producers
    s = rnd16();
    for (int k = 0; k < 40; k++) begin
      if (k % 10 == 0) for (int i = 0; i < 64; i++) ca[i] = rnd16();
      nxt = rnd16();
      run_a(s, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), nxt);
      s = nxt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
